pwm_multichannel: RTL and testbench

Multi-channel PWM generator with one shared period counter and independent per-channel duty values. Duty and period updates are double-buffered and take effect only at a period boundary, so every output is glitch-free. The block sits between the control logic and the motor and LED driver pins, and supersedes the single-channel fixed-window serializer.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_channel_cmp.sv | 45 ++++
 rtl/pwm_multichannel.sv | 161 ++++++++++++++++
 tb/tb_pwm_multichannel.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the multi-channel PWM generator.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package pwm_pkg;

   // Default width of the period counter, duty values and period value
   localparam int PWM_CNT_WIDTH_DEFAULT = 16;

   // Smallest period the block will run; shorter written periods are raised to this
   localparam int PWM_MIN_PERIOD = 2;

   // Counting mode latched at each period boundary
   typedef enum logic {
      MODE_EDGE   = 1'b0,
      MODE_CENTER = 1'b1
   } pwm_mode_e;

endpackage

// File: rtl/pwm_channel_cmp.sv
// One PWM channel: duty shadow/active pair, boundary load and registered compare.
// Latency: pwm output lags the shared counter by one clk.
// Backpressure: none; writes are always accepted into the shadow.
module pwm_channel_cmp
   import pwm_pkg::*;
#(
   parameter int CNT_WIDTH = PWM_CNT_WIDTH_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 i_run,
   input  logic                 i_load,
   input  logic                 i_wr,
   input  logic [CNT_WIDTH-1:0] i_val,
   input  logic [CNT_WIDTH-1:0] i_cnt,
   output logic                 o_pwm,
   output logic                 o_pending
);

   logic [CNT_WIDTH-1:0] r_duty_sh;
   logic [CNT_WIDTH-1:0] r_duty_act;
   logic                 r_pwm;

   // Shadow takes writes, active copies shadow at a boundary, output compares against active
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_duty_sh  <= '0;
         r_duty_act <= '0;
         r_pwm      <= 1'b0;
      end else begin
         if (i_wr) begin
            r_duty_sh <= i_val;
         end
         if (i_load) begin
            r_duty_act <= r_duty_sh;
         end
         // D >= P needs no special case: cnt never reaches P, so cnt < D holds all period
         r_pwm <= i_run && (i_cnt < r_duty_act);
      end
   end

   assign o_pwm     = r_pwm;
   assign o_pending = (r_duty_sh != r_duty_act);

endmodule

// File: rtl/pwm_multichannel.sv
// Multi-channel PWM: shared period counter, double-buffered period/duty applied at period boundaries.
// Latency: pwm_out and period_start lag the counter by one clk; shadow writes land at the next boundary.
// Backpressure: none; period_wr/duty_wr are strobes always accepted. Optional PWM_CENTER_EN adds center-aligned mode.
module pwm_multichannel
   import pwm_pkg::*;
#(
   parameter  int CHANNELS       = 4,
   parameter  int CNT_WIDTH      = PWM_CNT_WIDTH_DEFAULT,
   parameter  int PERIOD_DEFAULT = 2000,
   localparam int CH_W           = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 enable,
   input  logic                 period_wr,
   input  logic [CNT_WIDTH-1:0] period_val,
   input  logic                 duty_wr,
   input  logic [CH_W-1:0]      duty_ch,
   input  logic [CNT_WIDTH-1:0] duty_val,
   input  logic                 center,
   output logic [CHANNELS-1:0]  pwm_out,
   output logic                 period_start,
   output logic                 upd_pending
);

   localparam logic [CNT_WIDTH-1:0] LP_MIN_P = CNT_WIDTH'(PWM_MIN_PERIOD);
   localparam logic [CNT_WIDTH-1:0] LP_P_RST = CNT_WIDTH'(PERIOD_DEFAULT);
   localparam logic [CNT_WIDTH-1:0] LP_ONE   = CNT_WIDTH'(1);

   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] r_per_sh;
   logic [CNT_WIDTH-1:0] r_per_act;
   logic                 r_ps;

   logic [CNT_WIDTH-1:0] w_per_wr;
   logic [CNT_WIDTH-1:0] w_per_m1;
   logic                 w_at_top;
   logic                 w_cnt_zero;
   logic                 w_up;
   logic                 w_boundary;
   logic                 w_load;
   logic [CHANNELS-1:0]  w_pwm;
   logic [CHANNELS-1:0]  w_ch_pend;

   assign w_per_wr   = (period_val < LP_MIN_P) ? LP_MIN_P : period_val;
   assign w_per_m1   = r_per_act - LP_ONE;
   assign w_at_top   = (r_cnt == w_per_m1);
   assign w_cnt_zero = (r_cnt == '0);

`ifdef PWM_CENTER_EN
   pwm_mode_e r_mode;
   logic      r_down;

   assign w_up       = !r_down;
   assign w_boundary = (r_mode == MODE_CENTER) ? (r_down && w_cnt_zero) : w_at_top;

   // Mode follows the center input only at a boundary; direction turns at the top and at zero
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_mode <= MODE_EDGE;
         r_down <= 1'b0;
      end else begin
         if (w_load) begin
            r_mode <= center ? MODE_CENTER : MODE_EDGE;
         end
         if (!enable || (r_mode == MODE_EDGE)) begin
            r_down <= 1'b0;
         end else if (!r_down && w_at_top) begin
            r_down <= 1'b1;
         end else if (r_down && w_cnt_zero) begin
            r_down <= 1'b0;
         end
      end
   end

   // Shared counter: up/down in center mode (holding one cycle at each turnaround), wrap in edge mode
   always_ff @(posedge clk) begin
      if (!reset || !enable) begin
         r_cnt <= '0;
      end else if (r_mode == MODE_CENTER) begin
         if (r_down) begin
            if (!w_cnt_zero) begin
               r_cnt <= r_cnt - LP_ONE;
            end
         end else if (!w_at_top) begin
            r_cnt <= r_cnt + LP_ONE;
         end
      end else begin
         r_cnt <= w_at_top ? '0 : (r_cnt + LP_ONE);
      end
   end
`else
   logic w_unused_center;

   assign w_unused_center = center;
   assign w_up            = 1'b1;
   assign w_boundary      = w_at_top;

   // Shared counter: 0..P-1 then wrap
   always_ff @(posedge clk) begin
      if (!reset || !enable) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= w_at_top ? '0 : (r_cnt + LP_ONE);
      end
   end
`endif

   // While disabled, shadows flow straight into the active copies every cycle
   assign w_load = !enable || w_boundary;

   // Period shadow takes clamped writes; active copy refreshes at each load
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_per_sh  <= LP_P_RST;
         r_per_act <= LP_P_RST;
      end else begin
         if (period_wr) begin
            r_per_sh <= w_per_wr;
         end
         if (w_load) begin
            r_per_act <= r_per_sh;
         end
      end
   end

   // Period-start pulse, registered so it lines up with the first pwm_out cycle of the period
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_ps <= 1'b0;
      end else begin
         r_ps <= enable && w_cnt_zero && w_up;
      end
   end

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      logic w_wr;

      // Select codes at or above CHANNELS match no instance, so those writes drop
      assign w_wr = duty_wr && (duty_ch == CH_W'(gi));

      pwm_channel_cmp #(
         .CNT_WIDTH (CNT_WIDTH)
      ) u_ch (
         .clk       (clk),
         .reset     (reset),
         .i_run     (enable),
         .i_load    (w_load),
         .i_wr      (w_wr),
         .i_val     (duty_val),
         .i_cnt     (r_cnt),
         .o_pwm     (w_pwm[gi]),
         .o_pending (w_ch_pend[gi])
      );
   end

   assign pwm_out      = w_pwm;
   assign period_start = r_ps;
   assign upd_pending  = (r_per_sh != r_per_act) || (|w_ch_pend);

endmodule

// File: tb/tb_pwm_multichannel.sv
// Randomized and directed bench for pwm_multichannel against a period-position reference model.
// Latency: model predicts the registered outputs visible 1 time unit after each clk edge.
// Backpressure: n/a.
module tb_pwm_multichannel;

   localparam int CH   = 4;
   localparam int W    = 16;
   localparam int PDEF = 2000;

   logic          clk = 1'b0;
   logic          reset, enable, period_wr, duty_wr, center;
   logic [W-1:0]  period_val, duty_val;
   logic [1:0]    duty_ch;
   logic [CH-1:0] pwm_out;
   logic          period_start, upd_pending;

   int checks = 0;
   int errors = 0;

   // Reference model: position within the period, shadow/active values
   int            m_ph, m_P, m_Psh;
   int            m_D [CH];
   int            m_Dsh [CH];
   bit            m_center;
   logic [CH-1:0] m_pwm;
   logic          m_ps, m_pend;

   always #5 clk = ~clk;

   pwm_multichannel #(
      .CHANNELS       (CH),
      .CNT_WIDTH      (W),
      .PERIOD_DEFAULT (PDEF)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .period_wr    (period_wr),
      .period_val   (period_val),
      .duty_wr      (duty_wr),
      .duty_ch      (duty_ch),
      .duty_val     (duty_val),
      .center       (center),
      .pwm_out      (pwm_out),
      .period_start (period_start),
      .upd_pending  (upd_pending)
   );

   // One clock: advance the model with the inputs sampled at this edge, then release strobes
   task automatic tick();
      int len, cnt;
      bit bnd;
      @(posedge clk);
      if (!reset) begin
         m_ph = 0; m_P = PDEF; m_Psh = PDEF; m_center = 1'b0;
         for (int i = 0; i < CH; i++) begin m_D[i] = 0; m_Dsh[i] = 0; end
         m_pwm = '0; m_ps = 1'b0;
      end else begin
         len = m_center ? 2 * m_P : m_P;
         bnd = 1'b1;
         if (enable) begin
            cnt = (m_ph < m_P) ? m_ph : len - 1 - m_ph;
            for (int i = 0; i < CH; i++) m_pwm[i] = (cnt < m_D[i]);
            m_ps = (m_ph == 0);
            bnd  = (m_ph == len - 1);
            m_ph = bnd ? 0 : m_ph + 1;
         end else begin
            m_pwm = '0; m_ps = 1'b0; m_ph = 0;
         end
         if (bnd) begin
            m_P = m_Psh;
            m_D = m_Dsh;
`ifdef PWM_CENTER_EN
            m_center = center;
`endif
         end
         if (period_wr) m_Psh = (period_val < 2) ? 2 : int'(period_val);
         if (duty_wr) m_Dsh[duty_ch] = int'(duty_val);
      end
      m_pend = (m_Psh != m_P);
      for (int i = 0; i < CH; i++) if (m_Dsh[i] != m_D[i]) m_pend = 1'b1;
      #1;
      period_wr = 1'b0;
      duty_wr   = 1'b0;
   endtask

   task automatic skip_to_start();
      int guard;
      guard = 0;
      do begin tick(); guard++; end while (!m_ps && guard < 5000);
   endtask

   task automatic skip_to_ph(input int ph);
      for (int g = 0; g < 5000 && m_ph != ph; g++) tick();
   endtask

   task automatic wr_duty(input int ch, input int val);
      duty_ch = 2'(ch); duty_val = W'(val); duty_wr = 1'b1;
   endtask

   task automatic wr_period(input int val);
      period_val = W'(val); period_wr = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b0; enable = 1'b1; center = 1'b0; period_wr = 1'b0; duty_wr = 1'b0;
      duty_ch = '0; duty_val = '0; period_val = '0;
      tick(); tick();
      checks++; if (pwm_out !== 4'b0000) begin errors++; $display("FAIL reset_pwm_out: got %b expected 0000", pwm_out); end
      checks++; if (period_start !== 1'b0) begin errors++; $display("FAIL reset_period_start: got %b expected 0", period_start); end
      checks++; if (upd_pending !== 1'b0) begin errors++; $display("FAIL reset_upd_pending: got %b expected 0", upd_pending); end
      reset = 1'b1; enable = 1'b0;
      tick();
   endtask

   task automatic test_default_duty();
      int bad, hi0, hio, last, nper, bad_hi, bad_sp;
      wr_duty(0, 500);
      tick();
      checks++; if (upd_pending !== 1'b1) begin errors++; $display("FAIL dis_pending_rise: got %b expected 1", upd_pending); end
      tick();
      checks++; if (upd_pending !== 1'b0) begin errors++; $display("FAIL dis_pending_fall: got %b expected 0", upd_pending); end
      enable = 1'b1;
      bad = 0; hi0 = 0; hio = 0; last = -1; nper = 0; bad_hi = 0; bad_sp = 0;
      for (int k = 0; k <= 4000; k++) begin
         tick();
         if ({pwm_out, period_start, upd_pending} !== {m_pwm, m_ps, m_pend}) bad++;
         if (period_start) begin
            if (last >= 0) begin
               nper++;
               if (hi0 != 500 || hio != 0) bad_hi++;
               if (k - last != 2000) bad_sp++;
            end
            last = k; hi0 = 0; hio = 0;
         end
         hi0 += int'(pwm_out[0]);
         hio += int'(|pwm_out[3:1]);
      end
      checks++; if (nper !== 2) begin errors++; $display("FAIL default_periods: got %0d periods expected 2", nper); end
      checks++; if (bad_hi !== 0) begin errors++; $display("FAIL default_high_time: got %0d bad periods expected 0", bad_hi); end
      checks++; if (bad_sp !== 0) begin errors++; $display("FAIL default_spacing: got %0d bad spacings expected 0", bad_sp); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL default_model: got %0d differing cycles expected 0", bad); end
   endtask

   task automatic test_midperiod_write();
      int bad, hi, pc, n;
      enable = 1'b0;
      wr_period(10); wr_duty(1, 7);
      tick(); tick();
      enable = 1'b1;
      tick();
      skip_to_ph(2);
      wr_duty(1, 3);
      bad = 0; hi = 0; pc = 0; n = 0;
      tick();
      while (!period_start && n < 20) begin
         if ({pwm_out, period_start, upd_pending} !== {m_pwm, m_ps, m_pend}) bad++;
         hi += int'(pwm_out[1]); pc += int'(upd_pending); n++;
         tick();
      end
      checks++; if (hi !== 5) begin errors++; $display("FAIL mid_old_duty: got %0d high cycles expected 5", hi); end
      checks++; if (pc !== 7) begin errors++; $display("FAIL mid_pending_len: got %0d pending cycles expected 7", pc); end
      hi = 0; pc = 0;
      for (int k = 0; k < 10; k++) begin
         if ({pwm_out, period_start, upd_pending} !== {m_pwm, m_ps, m_pend}) bad++;
         hi += int'(pwm_out[1]); pc += int'(upd_pending);
         tick();
      end
      checks++; if (hi !== 3) begin errors++; $display("FAIL mid_new_duty: got %0d high cycles expected 3", hi); end
      checks++; if (pc !== 0) begin errors++; $display("FAIL mid_pending_after: got %0d pending cycles expected 0", pc); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL mid_model: got %0d differing cycles expected 0", bad); end
   endtask

   task automatic test_clamp();
      int bad, hi2, hi3, nps, bad_alt;
      logic prev;
      skip_to_start();
      wr_duty(2, 0); tick();
      wr_duty(3, 12); tick();
      skip_to_start();
      bad = 0; hi2 = 0; hi3 = 0;
      for (int k = 0; k < 20; k++) begin
         if ({pwm_out, period_start, upd_pending} !== {m_pwm, m_ps, m_pend}) bad++;
         hi2 += int'(pwm_out[2]); hi3 += int'(pwm_out[3]);
         tick();
      end
      checks++; if (hi2 !== 0) begin errors++; $display("FAIL clamp_zero_duty: got %0d high cycles expected 0", hi2); end
      checks++; if (hi3 !== 20) begin errors++; $display("FAIL clamp_full_duty: got %0d high cycles expected 20", hi3); end
      wr_period(1); tick();
      skip_to_start();
      nps = 0; bad_alt = 0; prev = 1'b0;
      for (int k = 0; k < 12; k++) begin
         if ({pwm_out, period_start, upd_pending} !== {m_pwm, m_ps, m_pend}) bad++;
         nps += int'(period_start);
         if (k > 0 && period_start === prev) bad_alt++;
         prev = period_start;
         tick();
      end
      checks++; if (nps !== 6 || bad_alt !== 0) begin errors++; $display("FAIL clamp_min_period: got %0d starts %0d breaks expected 6 starts 0 breaks", nps, bad_alt); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL clamp_model: got %0d differing cycles expected 0", bad); end
   endtask

   task automatic test_boundary_write();
      int bad, hi;
      wr_period(10); tick();
      skip_to_ph(9);
      wr_duty(1, 7); tick();
      skip_to_start();
      bad = 0; hi = 0;
      for (int k = 0; k < 10; k++) begin
         if ({pwm_out, period_start, upd_pending} !== {m_pwm, m_ps, m_pend}) bad++;
         hi += int'(pwm_out[1]);
         tick();
      end
      checks++; if (hi !== 3) begin errors++; $display("FAIL bnd_not_applied: got %0d high cycles expected 3", hi); end
      hi = 0;
      for (int k = 0; k < 10; k++) begin
         if ({pwm_out, period_start, upd_pending} !== {m_pwm, m_ps, m_pend}) bad++;
         hi += int'(pwm_out[1]);
         tick();
      end
      checks++; if (hi !== 7) begin errors++; $display("FAIL bnd_applied: got %0d high cycles expected 7", hi); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL bnd_model: got %0d differing cycles expected 0", bad); end
   endtask

   task automatic test_reset_mid();
      int bad, first, second, nps, anyhi;
      skip_to_ph(5);
      reset = 1'b0; tick();
      checks++; if ({pwm_out, period_start, upd_pending} !== 6'b0) begin errors++; $display("FAIL rstmid_outputs: got %b expected 000000", {pwm_out, period_start, upd_pending}); end
      reset = 1'b1;
      bad = 0; first = -1; second = -1; nps = 0; anyhi = 0;
      for (int k = 0; k < 2001; k++) begin
         tick();
         if ({pwm_out, period_start, upd_pending} !== {m_pwm, m_ps, m_pend}) bad++;
         if (period_start) begin
            nps++;
            if (first < 0) first = k; else if (second < 0) second = k;
         end
         anyhi += int'(|pwm_out);
      end
      checks++; if (nps !== 2 || second - first !== 2000) begin errors++; $display("FAIL rstmid_period: got %0d starts spacing %0d expected 2 starts spacing 2000", nps, second - first); end
      checks++; if (anyhi !== 0) begin errors++; $display("FAIL rstmid_duty_cleared: got %0d high cycles expected 0", anyhi); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL rstmid_model: got %0d differing cycles expected 0", bad); end
   endtask

   task automatic test_enable();
      int bad, hi0, nps;
      enable = 1'b0;
      wr_duty(0, 20); tick();
      wr_period(50); tick();
      bad = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         if (pwm_out !== 4'b0 || period_start !== 1'b0) bad++;
         if ({pwm_out, period_start, upd_pending} !== {m_pwm, m_ps, m_pend}) bad++;
      end
      checks++; if (bad !== 0) begin errors++; $display("FAIL en_low_outputs: got %0d bad cycles expected 0", bad); end
      checks++; if (upd_pending !== 1'b0) begin errors++; $display("FAIL en_low_pending: got %b expected 0", upd_pending); end
      enable = 1'b1; tick();
      checks++; if (period_start !== 1'b1) begin errors++; $display("FAIL en_rise_start: got %b expected 1", period_start); end
      checks++; if (pwm_out[0] !== 1'b1) begin errors++; $display("FAIL en_rise_pwm: got %b expected 1", pwm_out[0]); end
      hi0 = 0; nps = 0;
      for (int k = 0; k < 50; k++) begin
         hi0 += int'(pwm_out[0]); nps += int'(period_start);
         tick();
      end
      checks++; if (hi0 !== 20 || nps !== 1 || period_start !== 1'b1) begin errors++; $display("FAIL en_period: got %0d high %0d starts next_start %b expected 20 high 1 start next_start 1", hi0, nps, period_start); end
   endtask

   task automatic test_random();
      int bad;
      logic [6:0] got, exp;
      wr_period(12); tick();
      bad = 0; got = '0; exp = '0;
      for (int k = 0; k < 3000; k++) begin
         enable = ($urandom_range(0, 99) < 97);
         if ($urandom_range(0, 7) == 0) wr_duty(int'($urandom_range(0, 3)), int'($urandom_range(0, 24)));
         if ($urandom_range(0, 15) == 0) wr_period(int'($urandom_range(0, 20)));
         tick();
         if ({pwm_out, period_start, upd_pending} !== {m_pwm, m_ps, m_pend}) begin
            if (bad == 0) begin got = {1'b0, pwm_out, period_start, upd_pending}; exp = {1'b0, m_pwm, m_ps, m_pend}; end
            bad++;
         end
      end
      enable = 1'b1;
      checks++; if (bad !== 0) begin errors++; $display("FAIL random_model: %0d differing cycles, first got %b expected %b", bad, got, exp); end
   endtask

`ifdef PWM_CENTER_EN
   task automatic test_center();
      int bad, hi, nps;
      enable = 1'b0; center = 1'b1;
      wr_period(10); tick();
      wr_duty(0, 4); tick();
      enable = 1'b1; tick();
      skip_to_start();
      bad = 0; hi = 0; nps = 0;
      for (int k = 0; k < 20; k++) begin
         if ({pwm_out, period_start, upd_pending} !== {m_pwm, m_ps, m_pend}) bad++;
         hi += int'(pwm_out[0]); nps += int'(period_start);
         tick();
      end
      checks++; if (hi !== 8 || nps !== 1 || period_start !== 1'b1) begin errors++; $display("FAIL center_period: got %0d high %0d starts expected 8 high 1 start", hi, nps); end
      checks++; if (bad !== 0) begin errors++; $display("FAIL center_model: got %0d differing cycles expected 0", bad); end
      center = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_default_duty();
      test_midperiod_write();
      test_clamp();
      test_boundary_write();
      test_reset_mid();
      test_enable();
      test_random();
`ifdef PWM_CENTER_EN
      test_center();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got no completion by time limit, expected completion");
      $fatal(1);
   end

endmodule
